axi_mem_tester: RTL and testbench

- AXI4 initiator (traffic generator and checker) that drives the AXI slave port of the SDRAM controller.
- Used for board bring-up and regression alongside, or instead of, the vjtag bridge master.
- Writes a deterministic address-derived pattern over a configured region using INCR bursts, reads the region back, compares every beat, and reports error count and first failing address.

---
 rtl/axi_mem_tester_pkg.sv | 28 ++
 rtl/axi_mem_tester_chk.sv | 68 ++++++
 rtl/axi_mem_tester.sv | 238 +++++++++++++++++++++++
 tb/tb_axi_mem_tester.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_tester_pkg.sv
// axi_mem_tester_pkg: shared types and constants for the AXI4 memory tester.
// Holds the FSM state encoding, fixed AXI field values and the data pattern
// that the write phase lays down and the read phase expects back.
package axi_mem_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_PROT_NONE  = 3'b000;
  localparam logic [3:0] AXI_STRB_ALL   = 4'hF;

  // Address-derived test word; plain XOR so every beat address is unique.
  function automatic logic [31:0] pattern(input logic [31:0] addr,
                                          input logic [31:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/axi_mem_tester_chk.sv
// axi_mem_tester_chk: per-beat response checker.
// Flags a beat as bad on non-OKAY response, wrong ID, data mismatch or a
// misplaced last flag (data and last comparisons are enabled per beat, so the
// same block serves write responses and read data). At most one error is
// counted per beat; the count saturates and the first bad address is held.
module axi_mem_tester_chk
  import axi_mem_tester_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        beat_valid_i,
  input  logic        cmp_data_i,
  input  logic [31:0] exp_data_i,
  input  logic [31:0] act_data_i,
  input  logic [1:0]  resp_i,
  input  logic [3:0]  id_i,
  input  logic        cmp_last_i,
  input  logic        exp_last_i,
  input  logic        act_last_i,
  input  logic [31:0] beat_addr_i,
  output logic [15:0] err_count_o,
  output logic [31:0] first_err_addr_o
);

  logic        beat_err;
  logic [15:0] err_count_q, err_count_d;
  logic [31:0] first_err_q, first_err_d;

  // Collapse every failure reason of the current beat into one error flag.
  always_comb begin
    beat_err = beat_valid_i &
               ((resp_i != AXI_RESP_OKAY) ||
                (id_i != AXI_ID) ||
                (cmp_data_i && (exp_data_i != act_data_i)) ||
                (cmp_last_i && (exp_last_i != act_last_i)));
  end

  // Saturating count; address captured only on the first error of a run.
  always_comb begin
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    if (clear_i) begin
      err_count_d = 16'd0;
      first_err_d = 32'd0;
    end else if (beat_err) begin
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
      if (err_count_q == 16'd0)    first_err_d = beat_addr_i;
    end
  end

  // Error state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count_q <= 16'd0;
      first_err_q <= 32'd0;
    end else begin
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
    end
  end

  assign err_count_o      = err_count_q;
  assign first_err_addr_o = first_err_q;

endmodule

// File: rtl/axi_mem_tester.sv
// axi_mem_tester: AXI4 traffic generator/checker for the SDRAM controller.
// Writes pattern(addr) over NUM_BURSTS INCR bursts of BURST_LEN beats, reads
// the region back and counts bad beats. One transaction outstanding at a time.
// Optional watchdog: define AXI_MEM_TESTER_TIMEOUT_EN to abort a stuck run
// after TIMEOUT_CYC idle cycles; otherwise timeout is tied low.
module axi_mem_tester
  import axi_mem_tester_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned NUM_BURSTS  = 16,
  parameter int unsigned BURST_LEN   = 8,
  parameter logic [3:0]  AXI_ID      = 4'h0,
  parameter logic [31:0] SEED        = 32'h1234_5678,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [31:0] first_err_addr,
  output logic        timeout,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [15:0] LAST_BURST  = 16'(NUM_BURSTS - 1);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);

  state_e      state_q, state_d;
  logic [15:0] burst_q, burst_d;
  logic [7:0]  beat_q, beat_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;

  logic        start_acc;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
  logic        last_beat, last_burst;
  logic        wd_fire;
  logic [31:0] burst_addr, beat_addr, exp_data;

  // Address arithmetic and handshake decode shared by all processes.
  always_comb begin
    burst_addr = ADDR_BASE + (32'(burst_q) * BURST_BYTES);
    beat_addr  = burst_addr + {22'd0, beat_q, 2'b00};
    exp_data   = pattern(beat_addr, SEED);
    last_beat  = (beat_q == LAST_BEAT);
    last_burst = (burst_q == LAST_BURST);
    start_acc  = (state_q == ST_IDLE) && start;
    aw_hs      = (state_q == ST_AW) && awready;
    w_hs       = (state_q == ST_W)  && wready;
    b_hs       = (state_q == ST_B)  && bvalid;
    ar_hs      = (state_q == ST_AR) && arready;
    r_hs       = (state_q == ST_R)  && rvalid;
    any_hs     = aw_hs | w_hs | b_hs | ar_hs | r_hs;
  end

`ifdef AXI_MEM_TESTER_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        wd_active;

  // Watchdog: restarts on any handshake or state change, fires at the limit.
  always_comb begin
    wd_active = (state_q inside {ST_AW, ST_W, ST_B, ST_AR, ST_R});
    wd_fire   = wd_active && !any_hs && (wd_q == 32'(TIMEOUT_CYC - 1));
    if (!wd_active || any_hs || (state_d != state_q)) wd_d = 32'd0;
    else                                             wd_d = wd_q + 32'd1;
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wd_q <= 32'd0;
    else          wd_q <= wd_d;
  end
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
  assign wd_fire = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: write phase bursts, then read phase bursts, then DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)              state_d = ST_AW;
      ST_AW:   if (aw_hs)              state_d = ST_W;
      ST_W:    if (w_hs && last_beat)  state_d = ST_B;
      ST_B:    if (b_hs)               state_d = last_burst ? ST_AR : ST_AW;
      ST_AR:   if (ar_hs)              state_d = ST_R;
      ST_R:    if (r_hs && last_beat)  state_d = last_burst ? ST_DONE : ST_AR;
      ST_DONE:                         state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
    if (wd_fire) state_d = ST_DONE;
  end

  // FSM outputs: valid/ready decoded from state so payload is stable until handshake.
  always_comb begin
    awid    = AXI_ID;
    awaddr  = burst_addr;
    awlen   = LAST_BEAT;
    awsize  = AXI_SIZE_4B;
    awburst = AXI_BURST_INCR;
    awprot  = AXI_PROT_NONE;
    awvalid = (state_q == ST_AW);
    wdata   = exp_data;
    wstrb   = AXI_STRB_ALL;
    wlast   = last_beat;
    wvalid  = (state_q == ST_W);
    bready  = (state_q == ST_B);
    arid    = AXI_ID;
    araddr  = burst_addr;
    arlen   = LAST_BEAT;
    arsize  = AXI_SIZE_4B;
    arburst = AXI_BURST_INCR;
    arprot  = AXI_PROT_NONE;
    arvalid = (state_q == ST_AR);
    rready  = (state_q == ST_R);
  end

  // Burst/beat counters and run status flags.
  always_comb begin
    burst_d   = burst_q;
    beat_d    = beat_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: if (start) begin
        burst_d   = 16'd0;
        beat_d    = 8'd0;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        pass_d    = 1'b0;
        timeout_d = 1'b0;
      end
      ST_W: if (w_hs) beat_d = last_beat ? 8'd0 : beat_q + 8'd1;
      ST_B: if (b_hs) burst_d = last_burst ? 16'd0 : burst_q + 16'd1;
      ST_R: if (r_hs) begin
        beat_d = last_beat ? 8'd0 : beat_q + 8'd1;
        if (last_beat) burst_d = last_burst ? 16'd0 : burst_q + 16'd1;
      end
      ST_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        pass_d = (err_count == 16'd0) && !timeout_q;
      end
      default: ;
    endcase
    if (wd_fire) timeout_d = 1'b1;
  end

  // Counter and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_q   <= 16'd0;
      beat_q    <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
    end
  end

  axi_mem_tester_chk #(
    .AXI_ID(AXI_ID)
  ) u_chk (
    .clk              (clk),
    .reset_n          (reset_n),
    .clear_i          (start_acc),
    .beat_valid_i     (b_hs | r_hs),
    .cmp_data_i       (state_q == ST_R),
    .exp_data_i       (exp_data),
    .act_data_i       (rdata),
    .resp_i           ((state_q == ST_B) ? bresp : rresp),
    .id_i             ((state_q == ST_B) ? bid : rid),
    .cmp_last_i       (state_q == ST_R),
    .exp_last_i       (last_beat),
    .act_last_i       (rlast),
    .beat_addr_i      ((state_q == ST_B) ? burst_addr : beat_addr),
    .err_count_o      (err_count),
    .first_err_addr_o (first_err_addr)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_axi_mem_tester.sv
// tb_axi_mem_tester: behavioural AXI slave with optional random stalls and
// fault injection, plus a spec-level model of the expected run outcome.
`timescale 1ns/1ps
module tb_axi_mem_tester;

  localparam logic [31:0] P_BASE = 32'h0000_0000;
  localparam int          P_NB   = 2;
  localparam int          P_LEN  = 4;
  localparam logic [31:0] P_SEED = 32'h1234_5678;
  localparam logic [3:0]  P_ID   = 4'h0;
  localparam int          P_TO   = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;
  logic [3:0]  awid, arid;
  logic [31:0] awaddr, araddr, wdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, arburst;
  logic        awvalid, wvalid, wlast, bready, arvalid, rready;
  logic [3:0]  wstrb;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0;
  logic        rvalid = 1'b0, rlast = 1'b0;
  logic [3:0]  bid = 4'h0, rid = 4'h0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = 32'h0;

  int checks = 0;
  int failures = 0;

  bit          stall_en = 1'b0;
  bit          never_ar = 1'b0;
  logic [31:0] corrupt_addr = 32'hFFFF_FFFF;
  int          bresp_err_burst = -1;
  int          proto_err = 0;
  logic [31:0] aw_log[$];
  logic [31:0] ar_log[$];
  logic [31:0] w_log[$];
  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  axi_mem_tester #(
    .ADDR_BASE(P_BASE), .NUM_BURSTS(P_NB), .BURST_LEN(P_LEN),
    .AXI_ID(P_ID), .SEED(P_SEED), .TIMEOUT_CYC(P_TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr),
    .timeout(timeout),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  function automatic int stall_len();
    return stall_en ? int'($urandom_range(0, 5)) : 0;
  endfunction

  // Spec-level reference: pattern and expected error tally for current faults.
  function automatic logic [31:0] ref_pattern(input logic [31:0] a);
    return a ^ P_SEED;
  endfunction

  function automatic logic [31:0] ref_burst_addr(input int b);
    return P_BASE + 32'(b * P_LEN * 4);
  endfunction

  task automatic model_errors(output int e, output logic [31:0] f);
    logic [31:0] a;
    e = 0;
    f = 32'h0;
    for (int b = 0; b < P_NB; b++) begin
      if (b == bresp_err_burst) begin
        if (e == 0) f = ref_burst_addr(b);
        e++;
      end
    end
    for (int b = 0; b < P_NB; b++) begin
      for (int k = 0; k < P_LEN; k++) begin
        a = ref_burst_addr(b) + 32'(k * 4);
        if (a == corrupt_addr) begin
          if (e == 0) f = a;
          e++;
        end
      end
    end
  endtask

  // Behavioural slave: decides its outputs at each falling edge for the next rising edge.
  initial begin : slave
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, w_beat, r_beat;
    bit aw_open, b_pend, r_act, hs_b_prev, hs_r_prev;
    bit aw_stall, ar_stall, w_stall, w_last_prev;
    logic [31:0] aw_a, ar_a, a, aw_a_prev, ar_a_prev, w_d_prev;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0; w_beat = 0; r_beat = 0;
    aw_open = 0; b_pend = 0; r_act = 0; hs_b_prev = 0; hs_r_prev = 0;
    aw_stall = 0; ar_stall = 0; w_stall = 0; w_last_prev = 0;
    aw_a = 0; ar_a = 0; a = 0; aw_a_prev = 0; ar_a_prev = 0; w_d_prev = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0; w_beat = 0; r_beat = 0;
        aw_open = 0; b_pend = 0; r_act = 0; hs_b_prev = 0; hs_r_prev = 0;
        aw_stall = 0; ar_stall = 0; w_stall = 0;
        continue;
      end
      if (aw_stall && (awvalid !== 1'b1 || awaddr !== aw_a_prev)) proto_err++;
      if (ar_stall && (arvalid !== 1'b1 || araddr !== ar_a_prev)) proto_err++;
      if (w_stall && (wvalid !== 1'b1 || wdata !== w_d_prev || wlast !== w_last_prev)) proto_err++;
      if (wvalid === 1'b1 && !aw_open) proto_err++;
      if (hs_b_prev) begin bvalid = 0; hs_b_prev = 0; end
      if (hs_r_prev) begin rvalid = 0; rlast = 0; hs_r_prev = 0; end
      awready = (aw_cnt == 0); if (aw_cnt > 0) aw_cnt--;
      wready  = (w_cnt == 0);  if (w_cnt > 0) w_cnt--;
      arready = !never_ar && (ar_cnt == 0); if (ar_cnt > 0) ar_cnt--;
      if (b_pend && !bvalid) begin
        if (b_cnt > 0) b_cnt--;
        else begin
          bvalid = 1;
          bid = P_ID;
          bresp = ((aw_log.size() - 1) == bresp_err_burst) ? 2'b10 : 2'b00;
        end
      end
      if (r_act && !rvalid) begin
        if (r_cnt > 0) r_cnt--;
        else begin
          a = ar_a + 32'(r_beat * 4);
          rvalid = 1;
          rid = P_ID;
          rresp = 2'b00;
          rdata = (mem.exists(a) ? mem[a] : 32'h0) ^ ((a == corrupt_addr) ? 32'h1 : 32'h0);
          rlast = (r_beat == P_LEN - 1);
        end
      end
      aw_stall = awvalid && !awready; aw_a_prev = awaddr;
      ar_stall = arvalid && !arready; ar_a_prev = araddr;
      w_stall = wvalid && !wready; w_d_prev = wdata; w_last_prev = wlast;
      if (awvalid && awready) begin
        aw_a = awaddr; aw_open = 1; w_beat = 0; aw_log.push_back(awaddr); aw_cnt = stall_len();
      end
      if (wvalid && wready) begin
        a = aw_a + 32'(w_beat * 4);
        mem[a] = wdata;
        w_log.push_back(wdata);
        if (wlast !== (w_beat == P_LEN - 1)) proto_err++;
        if (w_beat == P_LEN - 1) begin aw_open = 0; b_pend = 1; b_cnt = stall_len(); end
        else w_beat++;
        w_cnt = stall_len();
      end
      if (bvalid && bready) begin hs_b_prev = 1; b_pend = 0; end
      if (arvalid && arready) begin
        ar_a = araddr; ar_log.push_back(araddr); r_act = 1; r_beat = 0;
        r_cnt = stall_len(); ar_cnt = stall_len();
      end
      if (rvalid && rready) begin
        hs_r_prev = 1;
        if (r_beat == P_LEN - 1) r_act = 0; else r_beat++;
        r_cnt = stall_len();
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic run_once(output bit ok);
    aw_log.delete(); ar_log.delete(); w_log.delete();
    proto_err = 0;
    pulse_start();
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      if (done === 1'b1) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass: got %b expected 0", pass); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    checks++; if (err_count !== 16'h0) begin failures++; $display("FAIL reset_err_count: got %h expected 0", err_count); end
    checks++; if (first_err_addr !== 32'h0) begin failures++; $display("FAIL reset_first_err: got %h expected 0", first_err_addr); end
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
      failures++; $display("FAIL reset_valids: got %b expected 00000", {awvalid, wvalid, bready, arvalid, rready});
    end
    checks++;
    if ({awsize, awburst, arsize, arburst, wstrb} !== {3'b010, 2'b01, 3'b010, 2'b01, 4'hF}) begin
      failures++; $display("FAIL const_fields: got %h", {awsize, awburst, arsize, arburst, wstrb});
    end
    reset_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_ideal();
    bit ok;
    do_reset();
    stall_en = 0;
    run_once(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ideal_done: got %b expected 1", ok); end
    checks++; if (pass !== 1'b1) begin failures++; $display("FAIL ideal_pass: got %b expected 1", pass); end
    checks++; if (err_count !== 16'h0) begin failures++; $display("FAIL ideal_err: got %0d expected 0", err_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ideal_busy: got %b expected 0", busy); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL ideal_timeout: got %b expected 0", timeout); end
    checks++; if (proto_err !== 0) begin failures++; $display("FAIL ideal_proto: got %0d expected 0", proto_err); end
    checks++;
    if (aw_log.size() != P_NB || ar_log.size() != P_NB || w_log.size() != P_NB * P_LEN) begin
      failures++; $display("FAIL ideal_counts: got aw=%0d ar=%0d w=%0d", aw_log.size(), ar_log.size(), w_log.size());
    end else begin
      for (int b = 0; b < P_NB; b++) begin
        checks++; if (aw_log[b] !== ref_burst_addr(b)) begin failures++; $display("FAIL ideal_awaddr%0d: got %h expected %h", b, aw_log[b], ref_burst_addr(b)); end
        checks++; if (ar_log[b] !== ref_burst_addr(b)) begin failures++; $display("FAIL ideal_araddr%0d: got %h expected %h", b, ar_log[b], ref_burst_addr(b)); end
      end
      for (int i = 0; i < P_NB * P_LEN; i++) begin
        checks++;
        if (w_log[i] !== ref_pattern(P_BASE + 32'(i * 4))) begin
          failures++; $display("FAIL ideal_wdata%0d: got %h expected %h", i, w_log[i], ref_pattern(P_BASE + 32'(i * 4)));
        end
      end
    end
    $display("test_ideal pass=%b err=%0d", pass, err_count);
  endtask

  task automatic test_backpressure();
    bit ok;
    stall_en = 1;
    for (int it = 0; it < 3; it++) begin
      run_once(ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_done%0d: got %b expected 1", it, ok); end
      checks++; if (pass !== 1'b1) begin failures++; $display("FAIL bp_pass%0d: got %b expected 1", it, pass); end
      checks++; if (proto_err !== 0) begin failures++; $display("FAIL bp_stable%0d: got %0d violations expected 0", it, proto_err); end
      checks++;
      if (w_log.size() != P_NB * P_LEN) begin
        failures++; $display("FAIL bp_wcount%0d: got %0d expected %0d", it, w_log.size(), P_NB * P_LEN);
      end else if (w_log[P_NB * P_LEN - 1] !== ref_pattern(P_BASE + 32'((P_NB * P_LEN - 1) * 4))) begin
        failures++; $display("FAIL bp_wdata%0d: got %h", it, w_log[P_NB * P_LEN - 1]);
      end
      $display("test_backpressure run %0d pass=%b", it, pass);
    end
    stall_en = 0;
  endtask

  task automatic test_rdata_corrupt();
    bit ok; int e; logic [31:0] f;
    corrupt_addr = 32'h18;
    model_errors(e, f);
    run_once(ok);
    checks++; if (err_count !== 16'(e)) begin failures++; $display("FAIL corrupt_err: got %0d expected %0d", err_count, e); end
    checks++; if (first_err_addr !== f) begin failures++; $display("FAIL corrupt_first: got %h expected %h", first_err_addr, f); end
    checks++; if (pass !== 1'b0 || ok !== 1'b1) begin failures++; $display("FAIL corrupt_pass: got pass=%b done=%b expected 0/1", pass, ok); end
    corrupt_addr = 32'hFFFF_FFFF;
    $display("test_rdata_corrupt err=%0d first=%h", err_count, first_err_addr);
  endtask

  task automatic test_bresp_err();
    bit ok; int e; logic [31:0] f;
    bresp_err_burst = 1;
    model_errors(e, f);
    run_once(ok);
    checks++; if (err_count !== 16'(e)) begin failures++; $display("FAIL bresp_err: got %0d expected %0d", err_count, e); end
    checks++; if (first_err_addr !== f) begin failures++; $display("FAIL bresp_first: got %h expected %h", first_err_addr, f); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL bresp_pass: got %b expected 0", pass); end
    bresp_err_burst = -1;
    $display("test_bresp_err err=%0d first=%h", err_count, first_err_addr);
  endtask

  task automatic test_random_faults();
    bit ok; int e; logic [31:0] f; int ci;
    stall_en = 1;
    for (int it = 0; it < 5; it++) begin
      bresp_err_burst = int'($urandom_range(0, P_NB));
      if (bresp_err_burst == P_NB) bresp_err_burst = -1;
      ci = int'($urandom_range(0, P_NB * P_LEN));
      corrupt_addr = (ci == P_NB * P_LEN) ? 32'hFFFF_FFFF : P_BASE + 32'(ci * 4);
      model_errors(e, f);
      run_once(ok);
      checks++; if (err_count !== 16'(e)) begin failures++; $display("FAIL rand_err%0d: got %0d expected %0d", it, err_count, e); end
      checks++; if (first_err_addr !== f) begin failures++; $display("FAIL rand_first%0d: got %h expected %h", it, first_err_addr, f); end
      checks++; if (pass !== (e == 0)) begin failures++; $display("FAIL rand_pass%0d: got %b expected %b", it, pass, (e == 0)); end
      $display("test_random_faults run %0d bresp_burst=%0d corrupt=%h err=%0d", it, bresp_err_burst, corrupt_addr, err_count);
    end
    bresp_err_burst = -1;
    corrupt_addr = 32'hFFFF_FFFF;
    stall_en = 0;
  endtask

  task automatic test_back_to_back();
    bit ok; int n; int guard;
    aw_log.delete(); ar_log.delete(); w_log.delete();
    pulse_start();
    repeat (3) tick();
    pulse_start();
    n = 0; guard = 0;
    while (n < P_NB * P_LEN && guard < 4000) begin
      tick();
      guard++;
      if (rvalid === 1'b1 && rready === 1'b1) n++;
    end
    checks++; if (n != P_NB * P_LEN) begin failures++; $display("FAIL b2b_rbeats: got %0d expected %0d", n, P_NB * P_LEN); end
    tick();
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_donecycle: got busy=%b done=%b expected 1/0", busy, done); end
    pulse_start();
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL b2b_drop: got busy=%b done=%b expected 0/1", busy, done); end
    checks++; if (aw_log.size() != P_NB) begin failures++; $display("FAIL b2b_awcount: got %0d expected %0d", aw_log.size(), P_NB); end
    pulse_start();
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_accept: got busy=%b done=%b expected 1/0", busy, done); end
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      if (done === 1'b1) begin ok = 1; break; end
      tick();
    end
    checks++; if (ok !== 1'b1 || pass !== 1'b1) begin failures++; $display("FAIL b2b_rerun: got done=%b pass=%b expected 1/1", ok, pass); end
    $display("test_back_to_back pass=%b", pass);
  endtask

  task automatic test_mid_reset();
    bit ok; int guard;
    aw_log.delete(); ar_log.delete(); w_log.delete();
    pulse_start();
    guard = 0;
    while (wvalid !== 1'b1 && guard < 200) begin tick(); guard++; end
    checks++; if (wvalid !== 1'b1) begin failures++; $display("FAIL midrst_reach_w: got %b expected 1", wvalid); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, busy} !== 6'b0) begin
      failures++; $display("FAIL midrst_valids: got %b expected 000000", {awvalid, wvalid, bready, arvalid, rready, busy});
    end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    run_once(ok);
    checks++; if (ok !== 1'b1 || pass !== 1'b1) begin failures++; $display("FAIL midrst_rerun: got done=%b pass=%b expected 1/1", ok, pass); end
    $display("test_mid_reset pass=%b", pass);
  endtask

`ifdef AXI_MEM_TESTER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    do_reset();
    never_ar = 1;
    run_once(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL to_done: got %b expected 1", ok); end
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_flag: got %b expected 1", timeout); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL to_pass: got %b expected 0", pass); end
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL to_arvalid: got %b expected 0", arvalid); end
    never_ar = 0;
    do_reset();
    $display("test_timeout timeout=%b", timeout);
  endtask
`endif

  initial begin
    test_reset();
    test_ideal();
    test_backpressure();
    test_rdata_corrupt();
    test_bresp_err();
    test_random_faults();
    test_back_to_back();
    test_mid_reset();
`ifdef AXI_MEM_TESTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
